// File: rtl/ecall_pkg.sv
// rtl/ecall_pkg.sv - shared states and constants for the ecall requester and service unit
package ecall_pkg;
    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READ,
        FIRE,
        WAIT,
        WB
    } ecall_state_e;

    localparam logic [4:0] REG_A0   = 5'd10;
    localparam int         NUM_ARGS = 8;
    localparam int         SYS_EXIT = 93;
endpackage

// File: rtl/ecall_arg_collector.sv
// rtl/ecall_arg_collector.sv - READ-phase sequencer: walks a0..a7 through the register file and latches them
module ecall_arg_collector
    import ecall_pkg::*;
#(
    parameter int DATA_WIDTH = 64
)
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [DATA_WIDTH-1:0]                rf_rd_data,
    output logic [4:0]                           rf_rd_addr,
    output logic [NUM_ARGS-1:0][DATA_WIDTH-1:0]  args,
    output logic                                 done
);
    logic [3:0]                          idx_q, idx_d;
    logic [NUM_ARGS-1:0][DATA_WIDTH-1:0] args_q, args_d;
    logic [2:0]                          slot;

    // start is held by the top for the whole READ phase; idx restarts at 0 whenever it drops.
    // Read data lags the address by one cycle, so idx captures into the previous slot.
    always_comb begin
        idx_d      = 4'd0;
        args_d     = args_q;
        rf_rd_addr = 5'd0;
        done       = 1'b0;
        slot       = 3'(idx_q - 4'd1);
        if (start) begin
            if (idx_q < 4'(NUM_ARGS)) begin
                rf_rd_addr = REG_A0 + 5'(idx_q);
            end
            if (idx_q != 4'd0) begin
                args_d[slot] = rf_rd_data;
            end
            if (idx_q == 4'(NUM_ARGS)) begin
                done = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= 4'd0;
            args_q <= '0;
        end else begin
            idx_q  <= idx_d;
            args_q <= args_d;
        end
    end

    assign args = args_q;
endmodule

// File: rtl/ecall_issue.sv
// rtl/ecall_issue.sv - ECALL requester: drain stores, gather a0..a7, fire service unit, write back a0
module ecall_issue
    import ecall_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int SVC_LATENCY = 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ecall_valid,
    output logic                  ecall_ready,
    output logic                  drain_req,
    input  logic                  drain_done,
    output logic [4:0]            rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    output logic [DATA_WIDTH-1:0] svc_a0,
    output logic [DATA_WIDTH-1:0] svc_a1,
    output logic [DATA_WIDTH-1:0] svc_a2,
    output logic [DATA_WIDTH-1:0] svc_a3,
    output logic [DATA_WIDTH-1:0] svc_a4,
    output logic [DATA_WIDTH-1:0] svc_a5,
    output logic [DATA_WIDTH-1:0] svc_a6,
    output logic [DATA_WIDTH-1:0] svc_a7,
    output logic                  svc_trigger,
    input  logic [DATA_WIDTH-1:0] svc_result,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  ecall_done,
    output logic                  busy,
    output logic                  halt
);
    localparam logic [3:0] LAT = 4'(SVC_LATENCY);

    ecall_state_e                        state_q, state_d;
    logic [3:0]                          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]               result_q, result_d;
    logic                                halt_q, halt_d;
    logic                                rd_start, rd_done;
    logic [NUM_ARGS-1:0][DATA_WIDTH-1:0] args;

    ecall_arg_collector #(.DATA_WIDTH(DATA_WIDTH)) u_args (
        .clk        (clk),
        .reset      (reset),
        .start      (rd_start),
        .rf_rd_data (rf_rd_data),
        .rf_rd_addr (rf_rd_addr),
        .args       (args),
        .done       (rd_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        halt_d      = halt_q;
        drain_req   = 1'b0;
        rd_start    = 1'b0;
        svc_trigger = 1'b0;
        rf_wr_en    = 1'b0;
        ecall_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ecall_valid && !halt_q) state_d = DRAIN;
            end
            DRAIN: begin
                drain_req = 1'b1;
                if (drain_done) state_d = READ;
            end
            READ: begin
                rd_start = 1'b1;
                if (rd_done) state_d = FIRE;
            end
            FIRE: begin
                svc_trigger = 1'b1;
                cnt_d       = LAT;
                state_d     = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    result_d = svc_result;
                    state_d  = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB: begin
                ecall_done = 1'b1;
                // exit never returns to the program, so a0 is left untouched
                if (args[7] == DATA_WIDTH'(SYS_EXIT)) halt_d = 1'b1;
                else                                  rf_wr_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            result_q <= '0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            halt_q   <= halt_d;
        end
    end

    assign ecall_ready = reset && (state_q == IDLE) && !halt_q;
    assign busy        = (state_q != IDLE);
    assign halt        = halt_q;
    assign rf_wr_addr  = rf_wr_en ? REG_A0 : 5'd0;
    assign rf_wr_data  = result_q;
    assign svc_a0      = args[0];
    assign svc_a1      = args[1];
    assign svc_a2      = args[2];
    assign svc_a3      = args[3];
    assign svc_a4      = args[4];
    assign svc_a5      = args[5];
    assign svc_a6      = args[6];
    assign svc_a7      = args[7];
endmodule

// File: tb/tb_ecall_issue.sv
// tb/tb_ecall_issue.sv - directed + randomized bench for ecall_issue at service latencies 1 and 4
module tb_ecall_issue;
    localparam int DW    = 64;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ecall_valid = 1'b0;
    logic          drain_done = 1'b0;
    logic [DW-1:0] svc_result = '0;
    logic          sel = 1'b0;

    logic          a_ready, a_drq, a_trig, a_wen, a_done, a_busy, a_halt;
    logic          b_ready, b_drq, b_trig, b_wen, b_done, b_busy, b_halt;
    logic [4:0]    a_raddr, a_waddr, b_raddr, b_waddr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [DW-1:0] a_arg [8];
    logic [DW-1:0] b_arg [8];
    logic [DW-1:0] rf [32];

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit halt_m [2];

    always #5 clk = ~clk;

    ecall_issue #(.DATA_WIDTH(DW), .SVC_LATENCY(LAT_A)) u_a (
        .clk(clk), .reset(reset), .ecall_valid(ecall_valid & ~sel), .ecall_ready(a_ready),
        .drain_req(a_drq), .drain_done(drain_done), .rf_rd_addr(a_raddr), .rf_rd_data(a_rdata),
        .svc_a0(a_arg[0]), .svc_a1(a_arg[1]), .svc_a2(a_arg[2]), .svc_a3(a_arg[3]),
        .svc_a4(a_arg[4]), .svc_a5(a_arg[5]), .svc_a6(a_arg[6]), .svc_a7(a_arg[7]),
        .svc_trigger(a_trig), .svc_result(svc_result), .rf_wr_en(a_wen), .rf_wr_addr(a_waddr),
        .rf_wr_data(a_wdata), .ecall_done(a_done), .busy(a_busy), .halt(a_halt)
    );

    ecall_issue #(.DATA_WIDTH(DW), .SVC_LATENCY(LAT_B)) u_b (
        .clk(clk), .reset(reset), .ecall_valid(ecall_valid & sel), .ecall_ready(b_ready),
        .drain_req(b_drq), .drain_done(drain_done), .rf_rd_addr(b_raddr), .rf_rd_data(b_rdata),
        .svc_a0(b_arg[0]), .svc_a1(b_arg[1]), .svc_a2(b_arg[2]), .svc_a3(b_arg[3]),
        .svc_a4(b_arg[4]), .svc_a5(b_arg[5]), .svc_a6(b_arg[6]), .svc_a7(b_arg[7]),
        .svc_trigger(b_trig), .svc_result(svc_result), .rf_wr_en(b_wen), .rf_wr_addr(b_waddr),
        .rf_wr_data(b_wdata), .ecall_done(b_done), .busy(b_busy), .halt(b_halt)
    );

    // register file with one-cycle read latency, one read port per instance
    always @(posedge clk) begin
        a_rdata <= rf[a_raddr];
        b_rdata <= rf[b_raddr];
    end

    logic          o_ready, o_drq, o_trig, o_wen, o_done, o_busy, o_halt;
    logic [4:0]    o_raddr, o_waddr;
    logic [DW-1:0] o_wdata;
    logic [DW-1:0] o_arg [8];

    assign o_ready = sel ? b_ready : a_ready;
    assign o_drq   = sel ? b_drq   : a_drq;
    assign o_trig  = sel ? b_trig  : a_trig;
    assign o_wen   = sel ? b_wen   : a_wen;
    assign o_done  = sel ? b_done  : a_done;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_halt  = sel ? b_halt  : a_halt;
    assign o_raddr = sel ? b_raddr : a_raddr;
    assign o_waddr = sel ? b_waddr : a_waddr;
    assign o_wdata = sel ? b_wdata : a_wdata;
    always_comb begin
        for (int i = 0; i < 8; i++) o_arg[i] = sel ? b_arg[i] : a_arg[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rf(input bit is_exit);
        for (int i = 10; i < 18; i++) rf[i] = {$urandom, $urandom};
        if (is_exit) rf[17] = 64'd93;
        else if (rf[17] == 64'd93) rf[17] = 64'd94;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ready"}, 64'(a_ready), 64'd0);
        chk({tag, "_busy"},  64'(a_busy),  64'd0);
        chk({tag, "_drq"},   64'(a_drq),   64'd0);
        chk({tag, "_trig"},  64'(a_trig),  64'd0);
        chk({tag, "_wen"},   64'(a_wen),   64'd0);
        chk({tag, "_done"},  64'(a_done),  64'd0);
        chk({tag, "_halt"},  64'(a_halt),  64'd0);
        chk({tag, "_raddr"}, 64'(a_raddr), 64'd0);
        chk({tag, "_waddr"}, 64'(a_waddr), 64'd0);
        chk({tag, "_wdata"}, a_wdata,      64'd0);
        for (int i = 0; i < 8; i++) chk({tag, "_arg"}, a_arg[i], 64'd0);
    endtask

    // One ECALL on the selected instance. Timeline is counted from the accept edge:
    // cycle 1 is the first DRAIN cycle, drain_done is low for cycles 1..d_low.
    task automatic run_ecall(input string tag, input int d_low, input bit hold, input bit toggle,
                             input bit use_fixed, input logic [DW-1:0] fixed_res);
        int            lat;
        int            done_c;
        int            n_wr;
        int            n_acc;
        int            rd_first;
        logic [DW-1:0] wr_seen;
        logic [DW-1:0] exp_arg [8];
        logic [DW-1:0] drv [$];
        bit            is_exit;
        lat      = sel ? LAT_B : LAT_A;
        done_c   = -1;
        n_wr     = 0;
        n_acc    = 0;
        wr_seen  = '0;
        rd_first = 2 + d_low;
        for (int i = 0; i < 8; i++) exp_arg[i] = rf[10 + i];
        is_exit = (exp_arg[7] == 64'd93);

        chk({tag, "_ready_pre"}, 64'(o_ready), 64'd1);
        ecall_valid = 1'b1;
        drain_done  = (d_low == 0);
        step();
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            if (toggle)    ecall_valid = (c >= rd_first && c <= rd_first + 8) ? c[0] : 1'b0;
            else if (!hold) ecall_valid = 1'b0;
            drain_done = (c > d_low);
            svc_result = use_fixed ? fixed_res : {$urandom, $urandom};
            drv.push_back(svc_result);
            if (o_ready && ecall_valid) n_acc++;
            chk({tag, "_busy"},  64'(o_busy),  64'd1);
            chk({tag, "_ready"}, 64'(o_ready), 64'd0);
            chk({tag, "_drq"},   64'(o_drq),   64'(c <= d_low + 1));
            chk({tag, "_raddr"}, 64'(o_raddr),
                (c >= rd_first && c < rd_first + 8) ? 64'(10 + c - rd_first) : 64'd0);
            chk({tag, "_trig"},  64'(o_trig),  64'(c == rd_first + 9));
            if (o_wen) begin
                n_wr++;
                wr_seen = o_wdata;
                chk({tag, "_waddr"}, 64'(o_waddr), 64'd10);
            end
            if (o_done) done_c = c;
            else        step();
        end
        chk({tag, "_done_cycle"}, 64'(done_c), 64'(12 + lat + d_low));
        chk({tag, "_no_reaccept"}, 64'(n_acc), 64'd0);
        for (int i = 0; i < 8; i++) chk({tag, "_arg"}, o_arg[i], exp_arg[i]);
        if (is_exit) begin
            chk({tag, "_exit_nowrite"}, 64'(n_wr), 64'd0);
            halt_m[sel] = 1'b1;
        end else begin
            chk({tag, "_nwrite"}, 64'(n_wr), 64'd1);
            // service result is the value present SVC_LATENCY cycles after the trigger cycle
            chk({tag, "_wdata"}, wr_seen, drv[rd_first + 9 + lat - 1]);
        end
        step();
        if (!hold) ecall_valid = 1'b0;
        chk({tag, "_busy_post"},  64'(o_busy),  64'd0);
        chk({tag, "_halt_post"},  64'(o_halt),  64'(halt_m[sel]));
        chk({tag, "_ready_post"}, 64'(o_ready), 64'(!halt_m[sel]));
    endtask

    initial begin
        int n;
        bit seen_wr;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        halt_m[0] = 1'b0;
        halt_m[1] = 1'b0;

        reset = 1'b0;
        step();
        step();
        chk_cleared("reset");
        reset = 1'b1;
        step();
        chk("reset_release_ready", 64'(a_ready), 64'd1);

        // basic
        for (int i = 0; i < 8; i++) rf[10 + i] = 64'(i + 1);
        run_ecall("basic", 0, 1'b0, 1'b0, 1'b1, 64'hAB);

        // drain stall: drain_done low from the accept cycle for 20 cycles
        fill_rf(1'b0);
        run_ecall("drain", 19, 1'b0, 1'b0, 1'b0, '0);

        // busy guard
        fill_rf(1'b0);
        run_ecall("guard", 0, 1'b0, 1'b1, 1'b0, '0);

        for (int k = 0; k < 4; k++) begin
            sel = 1'($urandom_range(0, 1));
            fill_rf(1'b0);
            run_ecall("rand", int'($urandom_range(0, 6)), 1'b0, 1'b0, 1'b0, '0);
        end

        // back-to-back on the latency-4 instance
        sel = 1'b1;
        fill_rf(1'b0);
        run_ecall("b2b_1", 0, 1'b1, 1'b0, 1'b0, '0);
        fill_rf(1'b0);
        run_ecall("b2b_2", 0, 1'b0, 1'b0, 1'b0, '0);

        // exit syscall
        sel = 1'b0;
        fill_rf(1'b1);
        run_ecall("exit", 0, 1'b0, 1'b0, 1'b0, '0);
        ecall_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("halted_ready", 64'(a_ready), 64'd0);
            chk("halted_busy",  64'(a_busy),  64'd0);
            chk("halted_halt",  64'(a_halt),  64'd1);
        end
        ecall_valid = 1'b0;

        // reset one cycle after the trigger: no write-back may appear
        reset = 1'b0;
        step();
        reset = 1'b1;
        halt_m[0] = 1'b0;
        step();
        fill_rf(1'b0);
        ecall_valid = 1'b1;
        drain_done  = 1'b1;
        step();
        ecall_valid = 1'b0;
        seen_wr = 1'b0;
        n = 0;
        while (!a_trig && n < 40) begin
            if (a_wen) seen_wr = 1'b1;
            step();
            n++;
        end
        chk("rst_trig_seen", 64'(a_trig), 64'd1);
        step();
        reset = 1'b0;
        step();
        chk_cleared("rst_wait");
        if (a_wen) seen_wr = 1'b1;
        step();
        if (a_wen) seen_wr = 1'b1;
        reset = 1'b1;
        step();
        if (a_wen) seen_wr = 1'b1;
        chk("rst_no_write", 64'(seen_wr), 64'd0);
        chk("rst_ready", 64'(a_ready), 64'd1);
        fill_rf(1'b0);
        run_ecall("after_rst", 0, 1'b0, 1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
